demux1x4_16bit_buf: RTL
=======================

Name: demux1x4_16bit_buf

Overview:
1-to-4 registered distributor for the multicycle datapath. It is the write-side counterpart of the 4:1 16-bit source selector. A single 16-bit producer stream is steered, under a 2-bit select, into one of four single-entry holding registers, or into all four at once in broadcast mode. Each holding register feeds an independent consumer through a valid/ready handshake.

Parameters:
WIDTH, 16, data width of the input and of each output channel.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_data  input  WIDTH  data word from producer
in_sel  input  2  destination channel 0..3; ignored when in_bcast=1
in_bcast  input  1  1 = write in_data to all four channels
in_valid  input  1  producer offers in_data this cycle
in_ready  output  1  block accepts in_data this cycle (combinational)
out0_data  output  WIDTH  channel 0 held word (registered)
out1_data  output  WIDTH  channel 1 held word (registered)
out2_data  output  WIDTH  channel 2 held word (registered)
out3_data  output  WIDTH  channel 3 held word (registered)
out_valid  output  4  bit k = channel k holds an undelivered word (registered)
out_ready  input  4  bit k = consumer k takes the word this cycle
drop_err  output  1  sticky flag: in_valid seen with in_sel/in_bcast changed while stalled

Behaviour:
- Reset (clk edge with rst_n=0):
  - out_valid=4'b0000, all outK_data=0, drop_err=0.
  - in_ready is forced 0 while rst_n=0.
  - Reset mid-transfer discards held words. Nothing is accepted on the reset edge.
- Channel k "can load" is defined as: can_k = ~out_valid[k] | out_ready[k].
  - A draining channel is therefore reloadable in the same cycle, giving full throughput.
- in_ready:
  - Non-broadcast: in_ready = can_{in_sel}.
  - Broadcast: in_ready = can_0 & can_1 & can_2 & can_3.
  - in_ready is independent of in_valid.
- Accept: in_valid & in_ready at a clk edge.
  - Non-broadcast: out{in_sel}_data <= in_data, out_valid[in_sel] <= 1.
  - Broadcast: all four outK_data <= in_data, out_valid <= 4'b1111.
- Drain: out_valid[k] & out_ready[k] & no load into k this edge -> out_valid[k] <= 0.
  - outK_data keeps its last value after a drain.
- Simultaneous drain and load of the same channel: the consumer takes the old word, the new word replaces it, and out_valid[k] stays 1.
- out_ready[k] while out_valid[k]=0 has no effect.
- Channels not addressed are unaffected. Their drains proceed concurrently with a load elsewhere.
- Latency: a word accepted at edge N is visible on outK_data/out_valid[k] after edge N, i.e. 1 cycle.
- Stall protocol: once in_valid=1 and in_ready=0, the producer must hold in_data/in_sel/in_bcast/in_valid until accepted.
  - If in_sel or in_bcast changes while in_valid stays high and no accept occurred on the previous cycle, drop_err <= 1.
  - drop_err clears only on reset.
  - Implementation: register the previous stalled in_valid/in_sel/in_bcast.
- in_sel values are all legal (2 bits). There is no invalid-select case.
- Purely synchronous design. No combinational path from in_data to any output.
- The only combinational paths are out_ready/in_sel/in_bcast/rst_n -> in_ready.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles with in_valid=1, in_data=16'hFFFF -> out_valid=0000, all data=0, in_ready=0, drop_err=0. Release -> in_ready=1.
2. Directed steer: send 16'h1111 sel=0, 16'h2222 sel=1, 16'h3333 sel=2, 16'h4444 sel=3 on consecutive cycles with out_ready=0000 -> out_valid=1111, out0..3 = 1111/2222/3333/4444. A 5th word with sel=2 sees in_ready=0.
3. Full throughput: out_ready[1]=1 held high, stream 16'hA000..16'hA009 to sel=1 every cycle -> in_ready stays 1, out1_data steps one word per cycle, out_valid[1]=1 throughout, no loss.
4. Broadcast backpressure: channel 3 full with out_ready[3]=0, in_bcast=1, in_data=16'hBEEF -> in_ready=0. Raise out_ready[3] for one cycle -> accept, all four channels = BEEF, out_valid=1111.
5. Protocol violation: stalled on sel=0 (channel 0 full), then switch in_sel to 2 while in_valid=1 -> drop_err=1 next cycle and remains 1 until rst_n=0.
6. Reset mid-operation: out_valid=0101 holding words, assert rst_n=0 for one edge -> out_valid=0000 and data=0. Previously held words are never presented afterwards.

Source files
------------

// File: rtl/demux1x4_16bit_buf_if.sv
// Producer-side stream plus four consumer channels of the 1:4 registered distributor.
// The master drives the producer stream and the consumer readies; the slave is the distributor.
interface demux1x4_16bit_buf_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic             in_bcast;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic [WIDTH-1:0] out1_data;
   logic [WIDTH-1:0] out2_data;
   logic [WIDTH-1:0] out3_data;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic             drop_err;

   modport master (
      output in_data, in_sel, in_bcast, in_valid, out_ready,
      input  in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, drop_err
   );

   modport slave (
      input  in_data, in_sel, in_bcast, in_valid, out_ready,
      output in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, drop_err
   );
endinterface

// File: rtl/demux1x4_16bit_buf.sv
// 1:4 registered distributor: steers one producer stream into four single-entry holding
// registers (or all four in broadcast), each drained by its own valid/ready consumer.
module demux1x4_16bit_buf #(
   parameter int WIDTH = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   demux1x4_16bit_buf_if.slave bus
);
   logic [WIDTH-1:0] data_p1 [4];
   logic [3:0]       vld_p1;
   logic             drop_p1;
   logic             stall_vld_p1;
   logic [1:0]       stall_sel_p1;
   logic             stall_bcast_p1;

   logic [3:0] can;
   logic [3:0] load;
   logic       rdy;
   logic       acc;
   logic       sel_chg;

   // A draining channel counts as free, so a channel can be reloaded every cycle.
   always_comb begin
      can     = ~vld_p1 | bus.out_ready;
      rdy     = bus.in_bcast ? (&can) : can[bus.in_sel];
      acc     = bus.in_valid & rdy & rst_n;
      load    = 4'b0000;
      if (acc) load = bus.in_bcast ? 4'b1111 : (4'b0001 << bus.in_sel);
      sel_chg = stall_vld_p1 & bus.in_valid &
                ((bus.in_sel != stall_sel_p1) | (bus.in_bcast != stall_bcast_p1));
   end

   assign bus.in_ready = rdy & rst_n;

   // Stage p1: holding registers, per-channel valid and the stalled-offer snapshot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1         <= 4'b0000;
         drop_p1        <= 1'b0;
         stall_vld_p1   <= 1'b0;
         stall_sel_p1   <= 2'd0;
         stall_bcast_p1 <= 1'b0;
         for (int k = 0; k < 4; k++) data_p1[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (load[k]) begin
               data_p1[k] <= bus.in_data;
               vld_p1[k]  <= 1'b1;
            end else if (bus.out_ready[k]) begin
               vld_p1[k]  <= 1'b0;
            end
         end
         stall_vld_p1   <= bus.in_valid & ~rdy;
         stall_sel_p1   <= bus.in_sel;
         stall_bcast_p1 <= bus.in_bcast;
         if (sel_chg) drop_p1 <= 1'b1;
      end
   end

   assign bus.out0_data = data_p1[0];
   assign bus.out1_data = data_p1[1];
   assign bus.out2_data = data_p1[2];
   assign bus.out3_data = data_p1[3];
   assign bus.out_valid = vld_p1;
   assign bus.drop_err  = drop_p1;
endmodule
